// File: rtl/hash_pkg.sv
// Shared definitions for the hash table and its request batcher.
// Holds the lane opcode encodings, the default key/value/data widths and the
// batcher FSM state type.
package hash_pkg;

  localparam logic [1:0] OPT_READ   = 2'b00;
  localparam logic [1:0] OPT_WRITE  = 2'b01;
  localparam logic [1:0] OPT_DELETE = 2'b10;
  localparam logic [1:0] OPT_NOP    = 2'b11;

  localparam int unsigned DEFAULT_KEY_WIDTH   = 32;
  localparam int unsigned DEFAULT_VALUE_WIDTH = 31;
  // One stored entry: key, value and an occupied flag.
  localparam int unsigned DEFAULT_DATA_WIDTH  = DEFAULT_KEY_WIDTH + DEFAULT_VALUE_WIDTH + 1;

  typedef enum logic [0:0] {
    StEmpty,
    StFilling
  } batch_state_e;

endpackage

// File: rtl/hash_key_conflict.sv
// Combinational hazard detector for the request batcher.
// Flags a conflict when the incoming key matches any valid open lane and at
// least one of the two opcodes is not a read (read/read is harmless).
// Ports:
//   in_key, in_opt : incoming request key and opcode
//   lane_key       : NUM_RD packed lane keys, lane i at [i*KEY_WIDTH +: KEY_WIDTH]
//   lane_opt       : NUM_RD packed 2-bit lane opcodes
//   lane_valid     : per-lane occupied flags
//   conflict       : single hazard bit
module hash_key_conflict
  import hash_pkg::*;
#(
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
  input  logic [KEY_WIDTH-1:0]        in_key,
  input  logic [1:0]                  in_opt,
  input  logic [NUM_RD*KEY_WIDTH-1:0] lane_key,
  input  logic [2*NUM_RD-1:0]         lane_opt,
  input  logic [NUM_RD-1:0]           lane_valid,
  output logic                        conflict
);

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (lane_valid[i] && (lane_key[i*KEY_WIDTH +: KEY_WIDTH] == in_key) &&
          ((lane_opt[2*i +: 2] != OPT_READ) || (in_opt != OPT_READ))) begin
        conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_req_batcher.sv
// Request packer in front of the hash table. Accepts one request per cycle on
// a valid/ready stream and issues NUM_RD-wide batches to the table lane buses
// for exactly one cycle each. A batch closes when full, when a new request
// hazards on an open key, on flush, or after FLUSH_CYCLES idle cycles.
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   s_valid/s_ready/s_key/s_value/s_opt : request stream (opt 11 is dropped)
//   flush                           : force issue of the open batch
//   key/value/opt/en_in             : registered lane buses; qualify on en_in
//   issue_cnt                       : batches issued since reset (wraps)
// NUM_RD and NUM_WR must be equal; FLUSH_CYCLES must lie in 1..255.
module hash_req_batcher
  import hash_pkg::*;
#(
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned NUM_WR       = 2,
  parameter int unsigned KEY_WIDTH    = DEFAULT_KEY_WIDTH,
  parameter int unsigned VALUE_WIDTH  = DEFAULT_VALUE_WIDTH,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [KEY_WIDTH-1:0]          s_key,
  input  logic [VALUE_WIDTH-1:0]        s_value,
  input  logic [1:0]                    s_opt,
  input  logic                          flush,
  output logic [NUM_RD*KEY_WIDTH-1:0]   key,
  output logic [NUM_WR*VALUE_WIDTH-1:0] value,
  output logic [2*NUM_WR-1:0]           opt,
  output logic [NUM_WR-1:0]             en_in,
  output logic [31:0]                   issue_cnt
);

  localparam int unsigned CntW = $clog2(NUM_RD + 1);
  localparam int unsigned KW   = NUM_RD * KEY_WIDTH;
  localparam int unsigned VW   = NUM_RD * VALUE_WIDTH;
  localparam int unsigned OW   = 2 * NUM_RD;

  batch_state_e       state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [7:0]         timer_q, timer_d;
  logic [KW-1:0]      buf_key_q, buf_key_d;
  logic [VW-1:0]      buf_val_q, buf_val_d;
  logic [OW-1:0]      buf_opt_q, buf_opt_d;
  logic [KW-1:0]      key_q, key_d;
  logic [VW-1:0]      value_q, value_d;
  logic [OW-1:0]      opt_q, opt_d;
  logic [NUM_RD-1:0]  en_q, en_d;
  logic [31:0]        issue_cnt_q, issue_cnt_d;

  logic               accept, placed, conflict, timeout, issue;
  logic [NUM_RD-1:0]  lane_valid;
  // Open lanes with the incoming request appended at lane count_q.
  logic [KW-1:0]      mrg_key;
  logic [VW-1:0]      mrg_val;
  logic [OW-1:0]      mrg_opt;
  logic [NUM_RD-1:0]  mrg_valid;
  // Lanes selected for issue this cycle.
  logic [KW-1:0]      iss_key;
  logic [VW-1:0]      iss_val;
  logic [OW-1:0]      iss_opt;
  logic [NUM_RD-1:0]  iss_valid;

  assign s_ready = reset;
  assign accept  = s_valid && s_ready;
  assign placed  = accept && (s_opt != OPT_NOP);

  always_comb begin
    for (int i = 0; i < int'(NUM_RD); i++) begin
      lane_valid[i] = (i < int'(count_q));
    end
  end

  hash_key_conflict #(
    .NUM_RD    (NUM_RD),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_conflict (
    .in_key     (s_key),
    .in_opt     (s_opt),
    .lane_key   (buf_key_q),
    .lane_opt   (buf_opt_q),
    .lane_valid (lane_valid),
    .conflict   (conflict)
  );

  always_comb begin
    mrg_key   = buf_key_q;
    mrg_val   = buf_val_q;
    mrg_opt   = buf_opt_q;
    mrg_valid = lane_valid;
    if (placed) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (i == int'(count_q)) begin
          mrg_key[i*KEY_WIDTH +: KEY_WIDTH]     = s_key;
          mrg_val[i*VALUE_WIDTH +: VALUE_WIDTH] = s_value;
          mrg_opt[2*i +: 2]                     = s_opt;
          mrg_valid[i]                          = 1'b1;
        end
      end
    end
  end

  // A placed accept restarts the idle window, so it never counts as a timeout.
  // Comparing against timer+1 lands the issue FLUSH_CYCLES cycles after the
  // last placed accept.
  assign timeout = (state_q == StFilling) && !placed &&
                   (({1'b0, timer_q} + 9'd1) >= 9'(FLUSH_CYCLES));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    buf_key_d = buf_key_q;
    buf_val_d = buf_val_q;
    buf_opt_d = buf_opt_q;
    issue     = 1'b0;
    iss_key   = buf_key_q;
    iss_val   = buf_val_q;
    iss_opt   = buf_opt_q;
    iss_valid = lane_valid;

    if (placed && conflict) begin
      // Issue the open lanes only; carry the incoming request as lane 0.
      issue                            = 1'b1;
      buf_key_d                        = '0;
      buf_val_d                        = '0;
      buf_opt_d                        = '0;
      buf_key_d[KEY_WIDTH-1:0]         = s_key;
      buf_val_d[VALUE_WIDTH-1:0]       = s_value;
      buf_opt_d[1:0]                   = s_opt;
      count_d                          = CntW'(1);
      state_d                          = StFilling;
    end else if ((placed && (count_q == CntW'(NUM_RD - 1))) ||
                 (flush && ((count_q != '0) || placed))) begin
      issue     = 1'b1;
      iss_key   = mrg_key;
      iss_val   = mrg_val;
      iss_opt   = mrg_opt;
      iss_valid = mrg_valid;
      count_d   = '0;
      state_d   = StEmpty;
    end else if (placed) begin
      buf_key_d = mrg_key;
      buf_val_d = mrg_val;
      buf_opt_d = mrg_opt;
      count_d   = count_q + CntW'(1);
      state_d   = StFilling;
      timer_d   = '0;
    end else if (timeout) begin
      issue   = 1'b1;
      count_d = '0;
      state_d = StEmpty;
    end else if ((state_q == StFilling) && (timer_q != 8'(FLUSH_CYCLES))) begin
      timer_d = timer_q + 8'd1;
    end

    if (issue) begin
      timer_d = '0;
    end
  end

  // Lane output registers hold their contents between issues.
  always_comb begin
    key_d       = key_q;
    value_d     = value_q;
    opt_d       = opt_q;
    en_d        = '0;
    issue_cnt_d = issue_cnt_q;
    if (issue) begin
      en_d        = iss_valid;
      issue_cnt_d = issue_cnt_q + 32'd1;
      for (int i = 0; i < int'(NUM_RD); i++) begin
        key_d[i*KEY_WIDTH +: KEY_WIDTH] =
            iss_valid[i] ? iss_key[i*KEY_WIDTH +: KEY_WIDTH] : '0;
        value_d[i*VALUE_WIDTH +: VALUE_WIDTH] =
            iss_valid[i] ? iss_val[i*VALUE_WIDTH +: VALUE_WIDTH] : '0;
        opt_d[2*i +: 2] = iss_valid[i] ? iss_opt[2*i +: 2] : 2'b00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StEmpty;
      count_q     <= '0;
      timer_q     <= '0;
      buf_key_q   <= '0;
      buf_val_q   <= '0;
      buf_opt_q   <= '0;
      key_q       <= '0;
      value_q     <= '0;
      opt_q       <= '0;
      en_q        <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      buf_key_q   <= buf_key_d;
      buf_val_q   <= buf_val_d;
      buf_opt_q   <= buf_opt_d;
      key_q       <= key_d;
      value_q     <= value_d;
      opt_q       <= opt_d;
      en_q        <= en_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign key       = key_q;
  assign value     = value_q;
  assign opt       = opt_q;
  assign en_in     = en_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_hash_req_batcher.sv
// Bench for hash_req_batcher: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_hash_req_batcher;
  import hash_pkg::*;

  localparam int NRD = 2;
  localparam int KW  = 32;
  localparam int VW  = 31;
  localparam int FC  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [KW-1:0]     s_key = '0;
  logic [VW-1:0]     s_value = '0;
  logic [1:0]        s_opt = 2'b00;
  logic              flush = 1'b0;
  logic [NRD*KW-1:0] key;
  logic [NRD*VW-1:0] value;
  logic [2*NRD-1:0]  opt;
  logic [NRD-1:0]    en_in;
  logic [31:0]       issue_cnt;

  hash_req_batcher #(
    .NUM_RD       (NRD),
    .NUM_WR       (NRD),
    .KEY_WIDTH    (KW),
    .VALUE_WIDTH  (VW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_key     (s_key),
    .s_value   (s_value),
    .s_opt     (s_opt),
    .flush     (flush),
    .key       (key),
    .value     (value),
    .opt       (opt),
    .en_in     (en_in),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic [1:0]    o;
  } req_t;

  // Model state: open batch as a queue, idle measured from the last placed accept.
  req_t              open_q[$];
  int                cyc_n = 0;
  int                last_place = 0;
  logic [NRD*KW-1:0] m_key = '0;
  logic [NRD*VW-1:0] m_val = '0;
  logic [2*NRD-1:0]  m_opt = '0;
  logic [NRD-1:0]    m_en = '0;
  logic [31:0]       m_cnt = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [KW-1:0] k, input logic [VW-1:0] val,
                            input logic [1:0] o, input logic fl, input logic rst);
    req_t nr;
    req_t out_q[$];
    bit   placed, hazard, fire;
    cyc_n++;
    if (!rst) begin
      open_q.delete();
      m_key = '0;
      m_val = '0;
      m_opt = '0;
      m_en  = '0;
      m_cnt = '0;
      return;
    end
    nr.k = k;
    nr.v = val;
    nr.o = o;
    placed = v && (o != OPT_NOP);
    hazard = 1'b0;
    if (placed) begin
      foreach (open_q[j]) begin
        if (open_q[j].k == k && (open_q[j].o != OPT_READ || o != OPT_READ)) hazard = 1'b1;
      end
    end
    fire = 1'b0;
    if (hazard) begin
      out_q = open_q;
      open_q.delete();
      open_q.push_back(nr);
      last_place = cyc_n;
      fire = 1'b1;
    end else if ((placed && open_q.size() + 1 == NRD) ||
                 (fl && (open_q.size() > 0 || placed))) begin
      out_q = open_q;
      if (placed) out_q.push_back(nr);
      open_q.delete();
      fire = 1'b1;
    end else if (placed) begin
      open_q.push_back(nr);
      last_place = cyc_n;
    end else if (open_q.size() > 0 && cyc_n - last_place >= FC) begin
      out_q = open_q;
      open_q.delete();
      fire = 1'b1;
    end
    m_en = '0;
    if (fire) begin
      m_key = '0;
      m_val = '0;
      m_opt = '0;
      foreach (out_q[j]) begin
        m_key[j*KW +: KW] = out_q[j].k;
        m_val[j*VW +: VW] = out_q[j].v;
        m_opt[j*2 +: 2]   = out_q[j].o;
        m_en[j]           = 1'b1;
      end
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return just after it.
  task automatic cyc(input logic v, input logic [KW-1:0] k, input logic [VW-1:0] val,
                     input logic [1:0] o, input logic fl, input logic rst);
    s_valid = v;
    s_key   = k;
    s_value = val;
    s_opt   = o;
    flush   = fl;
    reset   = rst;
    @(posedge clk);
    model_step(v, k, val, o, fl, rst);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("en_in", 64'(en_in), 64'(m_en));
      check("key", key, m_key);
      check("value", 64'(value), 64'(m_val));
      check("opt", 64'(opt), 64'(m_opt));
      check("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
      check("s_ready", 64'(s_ready), 64'(reset));
    end
  end

  initial begin
    logic [1:0] exp_en;

    cyc(0, 0, 0, OPT_READ, 0, 0);
    cyc(0, 0, 0, OPT_READ, 0, 0);
    chk_en = 1'b1;
    check("rst_en", 64'(en_in), 64'd0);
    check("rst_cnt", 64'(issue_cnt), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_key", key, 64'd0);

    // Four writes back to back -> two full batches.
    cyc(1, 32'd0, 31'h100, OPT_WRITE, 0, 1);
    check("t1_hold", 64'(en_in), 64'd0);
    cyc(1, 32'd1, 31'h101, OPT_WRITE, 0, 1);
    check("t1a_en", 64'(en_in), 64'h3);
    check("t1a_key", key, {32'd1, 32'd0});
    check("t1a_opt", 64'(opt), 64'h5);
    cyc(1, 32'd2, 31'h102, OPT_WRITE, 0, 1);
    check("t1_gap", 64'(en_in), 64'd0);
    cyc(1, 32'd3, 31'h103, OPT_WRITE, 0, 1);
    check("t1b_en", 64'(en_in), 64'h3);
    check("t1b_key", key, {32'd3, 32'd2});
    check("t1b_cnt", 64'(issue_cnt), 64'd2);

    // Write then read of the same key: write issues alone, read is carried.
    cyc(1, 32'd5, 31'h55, OPT_WRITE, 0, 1);
    cyc(1, 32'd5, 31'h0, OPT_READ, 0, 1);
    check("t2_en", 64'(en_in), 64'h1);
    check("t2_key", key, 64'd5);
    check("t2_opt", 64'(opt), 64'h1);
    cyc(0, 0, 0, OPT_READ, 1, 1);
    check("t2_carry_en", 64'(en_in), 64'h1);
    check("t2_carry_opt", 64'(opt), 64'h0);
    check("t2_cnt", 64'(issue_cnt), 64'd4);

    // Read/read on one key packs together.
    cyc(1, 32'd7, 31'h0, OPT_READ, 0, 1);
    cyc(1, 32'd7, 31'h0, OPT_READ, 0, 1);
    check("t3_en", 64'(en_in), 64'h3);
    check("t3_key", key, {32'd7, 32'd7});
    check("t3_opt", 64'(opt), 64'h0);

    // Timeout: issue visible 5 cycles after the accept, for one cycle.
    cyc(1, 32'd9, 31'h9, OPT_WRITE, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, 0, OPT_READ, 0, 1);
      exp_en = (i == 4) ? 2'b01 : 2'b00;
      check("t4_timeout_en", 64'(en_in), 64'(exp_en));
    end
    check("t4_cnt", 64'(issue_cnt), 64'd6);

    // Accept with flush in the same cycle.
    cyc(1, 32'd4, 31'h4, OPT_WRITE, 1, 1);
    check("t5_en", 64'(en_in), 64'h1);
    check("t5_key", key, 64'd4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, OPT_READ, 0, 1);
    check("t5_no_timeout", 64'(issue_cnt), 64'd7);

    // Reset mid-batch discards the open lane.
    cyc(1, 32'd6, 31'h6, OPT_WRITE, 0, 1);
    cyc(0, 0, 0, OPT_READ, 0, 0);
    check("t6_en", 64'(en_in), 64'd0);
    check("t6_cnt", 64'(issue_cnt), 64'd0);
    cyc(1, 32'd10, 31'ha, OPT_WRITE, 0, 1);
    cyc(1, 32'd11, 31'hb, OPT_DELETE, 0, 1);
    check("t6_pair_en", 64'(en_in), 64'h3);
    check("t6_pair_key", key, {32'd11, 32'd10});
    check("t6_pair_opt", 64'(opt), 64'h9);
    check("t6_pair_cnt", 64'(issue_cnt), 64'd1);

    // Randomized traffic on a small key space to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          32'($urandom_range(0, 3)),
          31'($urandom),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, OPT_READ, 0, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hash_req_batcher.md
# hash_req_batcher

Upstream request packer for `hash_table_16_URAM`. It accepts one key/value/opcode request per cycle on a valid/ready stream and packs requests into NUM_RD-wide batches. Each batch drives the table's `key`/`value`/`opt`/`en_in` lane buses for exactly one cycle. A batch closes early when a new request would hazard on a key already in it, on an explicit flush, or after an idle timeout.

## Interface
Parameters:
- NUM_RD, 2, number of lanes per batch; must equal NUM_WR
- NUM_WR, 2, write lanes; must equal NUM_RD
- KEY_WIDTH, 32, key width per lane
- VALUE_WIDTH, 31, value width per lane
- FLUSH_CYCLES, 4, idle cycles before a partial batch is issued; range 1..255

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- s_valid  in  1  request valid
- s_ready  out  1  request ready
- s_key  in  KEY_WIDTH  request key
- s_value  in  VALUE_WIDTH  request value; ignored for reads
- s_opt  in  2  opcode: 00 read, 01 write, 10 delete, 11 no-op
- flush  in  1  force issue of the open batch
- key  out  NUM_RD*KEY_WIDTH  lane keys to table; lane i at [i*KEY_WIDTH +: KEY_WIDTH]
- value  out  NUM_WR*VALUE_WIDTH  lane values to table
- opt  out  2*NUM_WR  lane opcodes to table
- en_in  out  NUM_WR  per-lane enable; nonzero only in the issue cycle
- issue_cnt  out  32  batches issued since reset, wraps at 2^32

## Operation
- Accept occurs when s_valid && s_ready. s_ready = reset (high whenever out of reset); the table never backpressures.
- An open batch buffer holds count lanes (0..NUM_RD), filled in arrival order starting at lane 0.
- FSM states:
  - EMPTY (count=0). An accept moves to FILLING.
  - FILLING (count>0). Issuing with no carried request returns to EMPTY.
- Opcode 11 is accepted and discarded. It is not placed, does not restart the timer, and does not close a batch.
- Conflict: the incoming key equals an open-lane key and at least one of the two opcodes is not read. Read/read on the same key is not a conflict.
- Close rules, evaluated each cycle in this priority order:
  1. Accept with conflict. Issue the open lanes only. The incoming request becomes lane 0 of a new batch (count=1), and the state stays FILLING.
  2. Accept making count reach NUM_RD. Issue all lanes including the incoming one; go to EMPTY.
  3. flush with count>0, or with an accepted non-conflicting request. Issue the open lanes plus the incoming one; go to EMPTY. flush with nothing open is ignored.
  4. Timer reaches FLUSH_CYCLES with count>0. Issue; go to EMPTY.
- Idle timer: cleared on every placed accept and on every issue. Otherwise it increments while FILLING and saturates at FLUSH_CYCLES.
- Issue mechanics:
  - The output registers load the lanes. en_in bit i is set for each filled lane.
  - Unfilled lanes get key/value/opt = 0 and en_in bit = 0.
  - issue_cnt increments by one.
- Reset mid-batch discards the open lanes with no issue. An issue cycle in flight is cleared, so en_in=0 on the cycle after reset is sampled low.

## Timing
- Reset values: key=0, value=0, opt=0, en_in=0, issue_cnt=0, s_ready=0, count=0, timer=0, state EMPTY.
- Latency: the batch close decision is made in cycle t; lane outputs and en_in are valid in cycle t+1 for exactly one cycle. In cycle t+2, en_in=0 unless another issue follows.
- Back-to-back issues are allowed every cycle, giving throughput of up to NUM_RD requests per NUM_RD cycles with no bubbles.
- key/value/opt hold their last issued contents while en_in=0. The table must qualify on en_in.
- Conflict, full, and flush may coincide. Priority 1 wins: the open lanes are issued and the incoming request is carried, so nothing is lost or duplicated.
- Timeout: a partial batch with no further accepts issues FLUSH_CYCLES cycles after its last placed accept, plus one cycle of output latency.

## Structure
- Shared package `hash_pkg`:
  - opcode localparams OPT_READ=2'b00, OPT_WRITE=2'b01, OPT_DELETE=2'b10, OPT_NOP=2'b11
  - default KEY_WIDTH/VALUE_WIDTH/DATA_WIDTH constants, also used by the table
- Sub-module `hash_key_conflict`: combinational. Inputs are the incoming key/opt and the NUM_RD lane keys, opts and valid bits. Output is a single conflict bit.
- The batcher holds the FSM, lane buffer, timer, output registers and issue_cnt.

## Test plan
- NUM_RD=2. Writes to keys 0,1,2,3 on consecutive cycles → two issues, one cycle after keys 1 and 3 are accepted: {key1,key0} en_in=11 opt=0101, then {key3,key2} en_in=11; issue_cnt=2.
- Write key 5, then read key 5 on the next cycle → issue lane0=key5 write with en_in=01; the read is carried as lane 0 of a new batch.
- Read key 7 twice on consecutive cycles → no conflict; one issue with en_in=11, both lanes read key 7.
- Write key 9, then idle with FLUSH_CYCLES=4 → en_in=01 asserted exactly 5 cycles after the accept, for one cycle.
- Accept write key 4 with flush=1 in the same cycle → issue next cycle with en_in=01; timer cleared; state EMPTY.
- Write key 6, then reset low → no issue; after release en_in=0, issue_cnt=0, and a following pair of requests issues normally.
